// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the FIFO read-side sequencer: FSM encodings,
// output buffer depth, statistics width and a saturating adder.
package fifo_rd_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int OB_DEPTH = 3;
   localparam int STAT_W   = 16;

   // Add a small increment to a counter, sticking at all-ones.
   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [2:0]        inc);
      logic [STAT_W:0] s;
      s = {1'b0, a} + {{(STAT_W-2){1'b0}}, inc};
      return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Bus bundle between the read sequencer, the async FIFO read port and the
// byte-stream consumer. master = sequencer side, slave = FIFO/consumer side.
interface fifo_rd_ctrl_if #(
   parameter int D_W = 8,
   parameter int A_W = 8
);
   logic           fifo_rdreq;
   logic [D_W-1:0] fifo_q;
   logic           fifo_rdempty;
   logic [A_W:0]   fifo_rdusedw;
   logic           m_valid;
   logic           m_ready;
   logic [D_W-1:0] m_data;

   modport master (
      output fifo_rdreq, m_valid, m_data,
      input  fifo_q, fifo_rdempty, fifo_rdusedw, m_ready
   );

   modport slave (
      input  fifo_rdreq, m_valid, m_data,
      output fifo_q, fifo_rdempty, fifo_rdusedw, m_ready
   );
endinterface

// File: rtl/fifo_rd_ctrl_obuf.sv
// fifo_rd_obuf: 3-entry register buffer absorbing the FIFO read latency.
// Entry 0 is always the head; a pop shifts the entries down and a push lands
// in the first free slot after that shift. clr empties the buffer and wins
// over push/pop.
module fifo_rd_obuf
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int D_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  logic           pop,
   input  logic           clr,
   input  logic [D_W-1:0] din,
   output logic [1:0]     occ,
   output logic [D_W-1:0] head
);
   logic [OB_DEPTH-1:0][D_W-1:0] mem;
   logic [1:0]                   occ_q;
   logic                         pop_ok;
   logic [1:0]                   wr_idx;

   assign pop_ok = pop & (occ_q != 2'd0);
   assign wr_idx = pop_ok ? occ_q - 2'd1 : occ_q;
   assign occ    = occ_q;
   assign head   = mem[0];

   // shift on pop, write incoming word behind the surviving entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '0;
         occ_q <= '0;
      end else if (clr) begin
         occ_q <= '0;
      end else begin
         if (pop_ok)
            for (int i = 0; i < OB_DEPTH-1; i++) mem[i] <= mem[i+1];
         if (push) mem[wr_idx] <= din;
         occ_q <= occ_q + {1'b0, push} - {1'b0, pop_ok};
      end
   end

   // credit logic upstream must never push into a full buffer
   assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop_ok && !clr && occ_q == 2'(OB_DEPTH)));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side sequencer for the 256x8 async FIFO (rdclk domain).
// Issues credit-limited reads, buffers returned words in fifo_rd_obuf and
// presents a valid/ready byte stream. flush drains and discards everything.
// Optional statistics counters are built when FIFO_RD_CTRL_STAT_EN is defined.
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int D_W = 8,
   parameter int A_W = 8
) (
   input  logic              rdclk,
   input  logic              rd_rst,
   input  logic              en,
   input  logic              flush,
   input  logic [A_W:0]      level_thr,
   fifo_rd_ctrl_if.master    bus,
   output logic              busy,
   output logic              flush_done,
   output logic              irq_level,
   output logic [STAT_W-1:0] stat_dlv,
   output logic [STAT_W-1:0] stat_drop
);
   state_t         state, state_nxt;
   logic           inflight;
   logic           armed;
   logic           rdreq;
   logic [1:0]     ob_occ;
   logic           pop, push, clr, credit_ok;
   logic [A_W+1:0] level_sum;

   assign pop       = bus.m_valid & bus.m_ready;
   assign clr       = flush & (state == ST_RUN);
   assign push      = inflight & (state == ST_RUN);
   // only registered terms: no path from m_ready to fifo_rdreq
   assign credit_ok = ({1'b0, ob_occ} + {2'b00, inflight}) < 3'(OB_DEPTH);
   assign bus.m_valid = (ob_occ != 2'd0);

   // FSM state register
   always_ff @(posedge rdclk or negedge rd_rst) begin
      if (!rd_rst) state <= ST_RUN;
      else         state <= state_nxt;
   end

   // FSM next state: flush drains until the FIFO is empty and nothing is in flight
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (flush) state_nxt = ST_DRAIN;
         ST_DRAIN: if (bus.fifo_rdempty && !inflight) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // FSM outputs: read issue per state and the done pulse
   always_comb begin
      rdreq      = 1'b0;
      flush_done = 1'b0;
      case (state)
         ST_RUN:   rdreq = armed & en & !bus.fifo_rdempty & credit_ok;
         ST_DRAIN: rdreq = armed & !bus.fifo_rdempty;
         ST_DONE:  flush_done = 1'b1;
         default:  ;
      endcase
   end
   assign bus.fifo_rdreq = rdreq;

   // read pipeline: armed keeps rdreq low while reset is held; inflight tracks RAM latency
   always_ff @(posedge rdclk or negedge rd_rst) begin
      if (!rd_rst) begin
         armed    <= 1'b0;
         inflight <= 1'b0;
      end else begin
         armed    <= 1'b1;
         inflight <= rdreq;
      end
   end

   fifo_rd_obuf #(.D_W(D_W)) u_obuf (
      .clk   (rdclk),
      .rst_n (rd_rst),
      .push  (push),
      .pop   (pop),
      .clr   (clr),
      .din   (bus.fifo_q),
      .occ   (ob_occ),
      .head  (bus.m_data)
   );

   assign level_sum = {1'b0, bus.fifo_rdusedw} + {{A_W{1'b0}}, ob_occ};

   // level interrupt, held low whenever the next state is not RUN
   always_ff @(posedge rdclk or negedge rd_rst) begin
      if (!rd_rst) irq_level <= 1'b0;
      else         irq_level <= (state_nxt == ST_RUN) && (level_sum >= {1'b0, level_thr});
   end

   assign busy = (state != ST_RUN) | (ob_occ != 2'd0) | inflight;

`ifdef FIFO_RD_CTRL_STAT_EN
   logic [2:0] drop_inc;

   // words lost this cycle: unpopped buffer entries plus a landing word on flush, returns in DRAIN
   always_comb begin
      drop_inc = 3'd0;
      if (clr)
         drop_inc = {1'b0, ob_occ - {1'b0, pop}} + {2'b00, inflight};
      else if (state == ST_DRAIN)
         drop_inc = {2'b00, inflight};
   end

   // saturating delivery and drop counters, cleared only by reset
   always_ff @(posedge rdclk or negedge rd_rst) begin
      if (!rd_rst) begin
         stat_dlv  <= '0;
         stat_drop <= '0;
      end else begin
         stat_dlv  <= sat_add(stat_dlv, {2'b00, pop});
         stat_drop <= sat_add(stat_drop, drop_inc);
      end
   end
`else
   assign stat_dlv  = '0;
   assign stat_drop = '0;
`endif

endmodule
